// File: rtl/string_buffer_writer.sv
`default_nettype none
// ============================================================================
// Module   : string_buffer_writer
// Purpose  : Packs the unescaped JSON string byte stream little-endian into
//            RAM words, writes them sequentially through port A, appends a
//            0x00 terminator and reports each string's start address/length.
// Options  : STRBUF_READBACK_EN - turns port B into a downstream read port
//            (rd_en / rd_addr / rd_data); otherwise port B is tied off.
// Revision : 1.0 - initial release
// ============================================================================
module string_buffer_writer #(
    parameter int WORDSIZE  = 8,
    parameter int ADDRWIDTH = 9,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 ram_ena,
    output logic                 ram_wea,
    output logic [ADDRWIDTH-1:0] ram_addra,
    output logic [WORDSIZE-1:0]  ram_dia,
    output logic                 ram_enb,
    output logic                 ram_web,
    output logic [ADDRWIDTH-1:0] ram_addrb,
    output logic [WORDSIZE-1:0]  ram_dib,
    input  logic [WORDSIZE-1:0]  ram_doa,
    input  logic [WORDSIZE-1:0]  ram_dob,
`ifdef STRBUF_READBACK_EN
    input  logic                 rd_en,
    input  logic [ADDRWIDTH-1:0] rd_addr,
    output logic [WORDSIZE-1:0]  rd_data,
`endif
    output logic                 str_done,
    output logic [ADDRWIDTH-1:0] str_start_addr,
    output logic [LEN_WIDTH-1:0] str_len,
    output logic                 full,
    output logic                 overflow
);

    localparam int C_BYTES  = WORDSIZE / 8;
    localparam int C_LANE_W = (C_BYTES > 1) ? $clog2(C_BYTES) : 1;
    localparam logic [C_LANE_W-1:0]  C_LAST_LANE = C_LANE_W'(C_BYTES - 1);
    localparam logic [ADDRWIDTH-1:0] C_MAX_ADDR  = '1;
    localparam logic [LEN_WIDTH-1:0] C_LEN_MAX   = '1;

    // S_TERM_WORD: the last byte closed a word; the terminator word follows.
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PACK      = 2'd1,
        S_TERM_WORD = 2'd2,
        S_TERM      = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [WORDSIZE-1:0]    word_q, word_d;
    logic [C_LANE_W-1:0]    lane_q, lane_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [ADDRWIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDRWIDTH-1:0]   start_q, start_d;
    logic                   full_q, full_d;
    logic                   overflow_q, overflow_d;
    logic                   wea_q, wea_d;
    logic [ADDRWIDTH-1:0]   addra_q, addra_d;
    logic [WORDSIZE-1:0]    dia_q, dia_d;
    logic                   done_q, done_d;
    logic [ADDRWIDTH-1:0]   done_start_q, done_start_d;
    logic [LEN_WIDTH-1:0]   done_len_q, done_len_d;

    logic                   w_accept;
    logic                   w_full_now;
    logic                   w_last_write;
    logic [LEN_WIDTH-1:0]   w_len_inc;
    logic [ADDRWIDTH-1:0]   w_addr_inc;
    logic [ADDRWIDTH-1:0]   w_start;
    logic [WORDSIZE-1:0]    w_word;

    // State and output registers; reset drops any partial word silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            word_q       <= '0;
            lane_q       <= '0;
            len_q        <= '0;
            wr_addr_q    <= '0;
            start_q      <= '0;
            full_q       <= 1'b0;
            overflow_q   <= 1'b0;
            wea_q        <= 1'b0;
            addra_q      <= '0;
            dia_q        <= '0;
            done_q       <= 1'b0;
            done_start_q <= '0;
            done_len_q   <= '0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            lane_q       <= lane_d;
            len_q        <= len_d;
            wr_addr_q    <= wr_addr_d;
            start_q      <= start_d;
            full_q       <= full_d;
            overflow_q   <= overflow_d;
            wea_q        <= wea_d;
            addra_q      <= addra_d;
            dia_q        <= dia_d;
            done_q       <= done_d;
            done_start_q <= done_start_d;
            done_len_q   <= done_len_d;
        end
    end

    // Packing, write issue, terminator sequencing and full/overflow tracking.
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        lane_d       = lane_q;
        len_d        = len_q;
        wr_addr_d    = wr_addr_q;
        start_d      = start_q;
        wea_d        = 1'b0;
        addra_d      = addra_q;
        dia_d        = dia_q;
        done_d       = 1'b0;
        done_start_d = done_start_q;
        done_len_d   = done_len_q;

        w_accept     = in_valid && in_ready;
        // The write visible now targets the last word: no further writes.
        w_last_write = wea_q && (addra_q == C_MAX_ADDR);
        w_full_now   = full_q || w_last_write;
        w_len_inc    = (len_q == C_LEN_MAX) ? len_q : len_q + LEN_WIDTH'(1);
        w_addr_inc   = (wr_addr_q == C_MAX_ADDR) ? wr_addr_q : wr_addr_q + ADDRWIDTH'(1);
        w_start      = (len_q == '0) ? wr_addr_q : start_q;
        // Higher lanes are already zero, so this doubles as the zero-filled word.
        w_word       = word_q;
        for (int i = 0; i < C_BYTES; i++) begin
            if (lane_q == C_LANE_W'(i)) begin
                w_word[i*8 +: 8] = in_data;
            end
        end

        full_d     = w_full_now;
        // Full reached on anything other than the terminator write truncates a string.
        overflow_d = overflow_q || (!full_q && w_last_write && (state_q != S_TERM));

        case (state_q)
            S_IDLE: begin
                state_d = S_PACK;
            end
            S_PACK: begin
                if (full_q) begin
                    word_d = '0;
                    lane_d = '0;
                    len_d  = '0;
                end else if (w_accept) begin
                    if (w_full_now) begin
                        word_d = '0;
                        lane_d = '0;
                        len_d  = '0;
                    end else begin
                        len_d   = w_len_inc;
                        start_d = w_start;
                        if (in_last || (lane_q == C_LAST_LANE)) begin
                            wea_d     = 1'b1;
                            addra_d   = wr_addr_q;
                            dia_d     = w_word;
                            wr_addr_d = w_addr_inc;
                            word_d    = '0;
                            lane_d    = '0;
                        end else begin
                            word_d = w_word;
                            lane_d = lane_q + C_LANE_W'(1);
                        end
                        if (in_last) begin
                            if (lane_q == C_LAST_LANE) begin
                                state_d = S_TERM_WORD;
                            end else begin
                                // Terminator shares the word with the last bytes.
                                done_d       = 1'b1;
                                done_start_d = w_start;
                                done_len_d   = w_len_inc;
                                len_d        = '0;
                                state_d      = S_TERM;
                            end
                        end
                    end
                end
            end
            S_TERM_WORD: begin
                if (w_full_now) begin
                    len_d   = '0;
                    state_d = S_PACK;
                end else begin
                    wea_d        = 1'b1;
                    addra_d      = wr_addr_q;
                    dia_d        = '0;
                    wr_addr_d    = w_addr_inc;
                    done_d       = 1'b1;
                    done_start_d = start_q;
                    done_len_d   = len_q;
                    len_d        = '0;
                    state_d      = S_TERM;
                end
            end
            default: begin
                state_d = S_PACK;
            end
        endcase
    end

    assign in_ready       = (state_q == S_PACK) && !full_q;
    assign ram_ena        = wea_q;
    assign ram_wea        = wea_q;
    assign ram_addra      = addra_q;
    assign ram_dia        = dia_q;
    assign str_done       = done_q;
    assign str_start_addr = done_start_q;
    assign str_len        = done_len_q;
    assign full           = full_q;
    assign overflow       = overflow_q;

`ifdef STRBUF_READBACK_EN
    assign ram_enb   = rd_en;
    assign ram_web   = 1'b0;
    assign ram_addrb = rd_addr;
    assign ram_dib   = '0;
    assign rd_data   = ram_dob;

    logic unused_ok;
    assign unused_ok = ^ram_doa;
`else
    assign ram_enb   = 1'b0;
    assign ram_web   = 1'b0;
    assign ram_addrb = '0;
    assign ram_dib   = '0;

    logic unused_ok;
    assign unused_ok = ^{ram_doa, ram_dob};
`endif

endmodule
`default_nettype wire

// File: tb/tb_string_buffer_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_string_buffer_writer
// Purpose  : Directed self-checking bench for string_buffer_writer; three
//            instances cover 32-bit words, 8-bit words and a 4-word RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_string_buffer_writer;

    typedef struct {
        int          phase;
        int          dut;
        int          kind;   // 0 write, 1 str_done, 2 malformed write strobe
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    typedef struct {
        int    phase;
        int    dut;
        string s;
    } stim_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    ev_t   evq[$];
    ev_t   exp_tab[32];
    int    n_exp = 0;
    stim_t stim_tab[8];
    int    n_stim = 0;

    // ---------------- instance A: WORDSIZE 32, ADDRWIDTH 9 ----------------
    logic        in_valid_a = 0, in_last_a = 0, in_ready_a;
    logic [7:0]  in_data_a = 0;
    logic        ram_ena_a, ram_wea_a, ram_enb_a, ram_web_a;
    logic [8:0]  ram_addra_a, ram_addrb_a, str_start_addr_a;
    logic [31:0] ram_dia_a, ram_dib_a, ram_dob_a;
    logic [15:0] str_len_a;
    logic        str_done_a, full_a, overflow_a;
    logic [31:0] mem_a [512];
`ifdef STRBUF_READBACK_EN
    logic        rd_en_a = 0;
    logic [8:0]  rd_addr_a = 0;
    logic [31:0] rd_data_a;
`endif

    string_buffer_writer #(.WORDSIZE(32), .ADDRWIDTH(9), .LEN_WIDTH(16)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_data(in_data_a), .in_last(in_last_a), .in_ready(in_ready_a),
        .ram_ena(ram_ena_a), .ram_wea(ram_wea_a), .ram_addra(ram_addra_a), .ram_dia(ram_dia_a),
        .ram_enb(ram_enb_a), .ram_web(ram_web_a), .ram_addrb(ram_addrb_a), .ram_dib(ram_dib_a),
        .ram_doa(32'h0), .ram_dob(ram_dob_a),
`ifdef STRBUF_READBACK_EN
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
`endif
        .str_done(str_done_a), .str_start_addr(str_start_addr_a), .str_len(str_len_a),
        .full(full_a), .overflow(overflow_a)
    );

    // Dual-port RAM behind instance A
    always @(posedge clk) begin
        if (ram_ena_a && ram_wea_a) mem_a[ram_addra_a] <= ram_dia_a;
        if (ram_enb_a) ram_dob_a <= mem_a[ram_addrb_a];
    end

    // ---------------- instance B: WORDSIZE 8, ADDRWIDTH 9 ----------------
    logic        in_valid_b = 0, in_last_b = 0, in_ready_b;
    logic [7:0]  in_data_b = 0;
    logic        ram_ena_b, ram_wea_b, ram_enb_b, ram_web_b;
    logic [8:0]  ram_addra_b, ram_addrb_b, str_start_addr_b;
    logic [7:0]  ram_dia_b, ram_dib_b;
    logic [15:0] str_len_b;
    logic        str_done_b, full_b, overflow_b;
`ifdef STRBUF_READBACK_EN
    logic [7:0]  rd_data_b;
`endif

    string_buffer_writer #(.WORDSIZE(8), .ADDRWIDTH(9), .LEN_WIDTH(16)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_data(in_data_b), .in_last(in_last_b), .in_ready(in_ready_b),
        .ram_ena(ram_ena_b), .ram_wea(ram_wea_b), .ram_addra(ram_addra_b), .ram_dia(ram_dia_b),
        .ram_enb(ram_enb_b), .ram_web(ram_web_b), .ram_addrb(ram_addrb_b), .ram_dib(ram_dib_b),
        .ram_doa(8'h0), .ram_dob(8'h0),
`ifdef STRBUF_READBACK_EN
        .rd_en(1'b0), .rd_addr(9'h0), .rd_data(rd_data_b),
`endif
        .str_done(str_done_b), .str_start_addr(str_start_addr_b), .str_len(str_len_b),
        .full(full_b), .overflow(overflow_b)
    );

    // ---------------- instance C: WORDSIZE 8, ADDRWIDTH 2 ----------------
    logic        in_valid_c = 0, in_last_c = 0, in_ready_c;
    logic [7:0]  in_data_c = 0;
    logic        ram_ena_c, ram_wea_c, ram_enb_c, ram_web_c;
    logic [1:0]  ram_addra_c, ram_addrb_c, str_start_addr_c;
    logic [7:0]  ram_dia_c, ram_dib_c;
    logic [15:0] str_len_c;
    logic        str_done_c, full_c, overflow_c;
`ifdef STRBUF_READBACK_EN
    logic [7:0]  rd_data_c;
`endif

    string_buffer_writer #(.WORDSIZE(8), .ADDRWIDTH(2), .LEN_WIDTH(16)) u_c (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_c), .in_data(in_data_c), .in_last(in_last_c), .in_ready(in_ready_c),
        .ram_ena(ram_ena_c), .ram_wea(ram_wea_c), .ram_addra(ram_addra_c), .ram_dia(ram_dia_c),
        .ram_enb(ram_enb_c), .ram_web(ram_web_c), .ram_addrb(ram_addrb_c), .ram_dib(ram_dib_c),
        .ram_doa(8'h0), .ram_dob(8'h0),
`ifdef STRBUF_READBACK_EN
        .rd_en(1'b0), .rd_addr(2'h0), .rd_data(rd_data_c),
`endif
        .str_done(str_done_c), .str_start_addr(str_start_addr_c), .str_len(str_len_c),
        .full(full_c), .overflow(overflow_c)
    );

    // Event monitor: port A writes and str_done pulses, in time order
    always @(negedge clk) begin
        if (ram_ena_a || ram_wea_a)
            evq.push_back('{0, 0, (ram_ena_a && ram_wea_a) ? 0 : 2, 32'(ram_addra_a), ram_dia_a});
        if (str_done_a) evq.push_back('{0, 0, 1, 32'(str_start_addr_a), 32'(str_len_a)});
        if (ram_ena_b || ram_wea_b)
            evq.push_back('{0, 1, (ram_ena_b && ram_wea_b) ? 0 : 2, 32'(ram_addra_b), 32'(ram_dia_b)});
        if (str_done_b) evq.push_back('{0, 1, 1, 32'(str_start_addr_b), 32'(str_len_b)});
        if (ram_ena_c || ram_wea_c)
            evq.push_back('{0, 2, (ram_ena_c && ram_wea_c) ? 0 : 2, 32'(ram_addra_c), 32'(ram_dia_c)});
        if (str_done_c) evq.push_back('{0, 2, 1, 32'(str_start_addr_c), 32'(str_len_c)});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic add_exp(input int p, input int k, input int kind, input logic [31:0] a, input logic [31:0] d);
        exp_tab[n_exp] = '{p, k, kind, a, d};
        n_exp++;
    endtask

    task automatic add_stim(input int p, input int k, input string s);
        stim_tab[n_stim] = '{p, k, s};
        n_stim++;
    endtask

    task automatic drive(input int k, input logic v, input logic [7:0] b, input logic l);
        case (k)
            0: begin in_valid_a = v; in_data_a = b; in_last_a = l; end
            1: begin in_valid_b = v; in_data_b = b; in_last_b = l; end
            default: begin in_valid_c = v; in_data_c = b; in_last_c = l; end
        endcase
    endtask

    function automatic logic rdy(input int k);
        case (k)
            0: return in_ready_a;
            1: return in_ready_b;
            default: return in_ready_c;
        endcase
    endfunction

    // Present one byte from a falling edge; returns just after the accepting edge.
    task automatic push(input int k, input logic [7:0] b, input logic l, input int budget, output logic acc);
        acc = 1'b0;
        @(negedge clk);
        drive(k, 1'b1, b, l);
        for (int i = 0; i < budget; i++) begin
            if (rdy(k)) begin
                @(posedge clk);
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int k);
        @(negedge clk);
        drive(k, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_str(input int k, input string s);
        logic acc;
        for (int i = 0; i < s.len(); i++) begin
            push(k, s[i], (i == s.len() - 1), 20, acc);
            chk($sformatf("accept dut%0d byte%0d", k, i), 32'(acc), 32'd1);
        end
        idle(k);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        drive(2, 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_phase(input int p);
        ev_t g;
        for (int i = 0; i < n_exp; i++) begin
            if (exp_tab[i].phase == p) begin
                if (evq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL p%0d ev%0d: got no event required dut%0d kind%0d a=%h d=%h",
                             p, i, exp_tab[i].dut, exp_tab[i].kind, exp_tab[i].a, exp_tab[i].d);
                end else begin
                    g = evq.pop_front();
                    chk($sformatf("p%0d ev%0d dut*4+kind", p, i), 32'(g.dut * 4 + g.kind),
                        32'(exp_tab[i].dut * 4 + exp_tab[i].kind));
                    chk($sformatf("p%0d ev%0d addr/start", p, i), g.a, exp_tab[i].a);
                    chk($sformatf("p%0d ev%0d data/len", p, i), g.d, exp_tab[i].d);
                end
            end
        end
        chk($sformatf("p%0d extra events", p), 32'(evq.size()), 32'd0);
        evq.delete();
    endtask

    initial begin
        logic acc;

        // Expected events (phase, dut, kind, addr/start, data/len)
        add_exp(1, 0, 0, 32'd0, 32'h0000_6261);
        add_exp(1, 0, 1, 32'd0, 32'd2);
        add_exp(2, 0, 0, 32'd0, 32'h6463_6261);
        add_exp(2, 0, 0, 32'd1, 32'h0000_0000);
        add_exp(2, 0, 1, 32'd0, 32'd4);
        add_exp(2, 0, 0, 32'd2, 32'h0000_0065);
        add_exp(2, 0, 1, 32'd2, 32'd1);
        add_exp(3, 1, 0, 32'd0, 32'h78);
        add_exp(3, 1, 0, 32'd1, 32'h00);
        add_exp(3, 1, 1, 32'd0, 32'd1);
        add_exp(3, 1, 0, 32'd2, 32'h79);
        add_exp(3, 1, 0, 32'd3, 32'h7A);
        add_exp(3, 1, 0, 32'd4, 32'h00);
        add_exp(3, 1, 1, 32'd2, 32'd2);
        add_exp(4, 2, 0, 32'd0, 32'h11);
        add_exp(4, 2, 0, 32'd1, 32'h12);
        add_exp(4, 2, 0, 32'd2, 32'h13);
        add_exp(4, 2, 0, 32'd3, 32'h14);
        add_exp(5, 0, 0, 32'd0, 32'h0000_0071);
        add_exp(5, 0, 1, 32'd0, 32'd1);
        add_stim(2, 0, "abcd");
        add_stim(2, 0, "e");
        add_stim(3, 1, "x");
        add_stim(3, 1, "yz");

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset in_ready a", 32'(in_ready_a), 32'd0);
        chk("reset in_ready c", 32'(in_ready_c), 32'd0);
        chk("reset outputs a", {26'd0, ram_ena_a, ram_wea_a, str_done_a, full_a, overflow_a, ram_web_a}, 32'd0);
        chk("reset outputs c", {27'd0, ram_ena_c, ram_wea_c, str_done_c, full_c, overflow_c}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("in_ready after reset", {29'd0, in_ready_a, in_ready_b, in_ready_c}, 32'd7);
        evq.delete();

        // Phase 1: "ab" on 32-bit words, write visible one cycle after acceptance
        push(0, 8'h61, 1'b0, 20, acc);
        chk("p1 accept a", 32'(acc), 32'd1);
        push(0, 8'h62, 1'b1, 20, acc);
        chk("p1 accept b", 32'(acc), 32'd1);
        #1;
        chk("p1 latency wea", {30'd0, ram_ena_a, ram_wea_a}, 32'd3);
        chk("p1 latency dia", ram_dia_a, 32'h0000_6261);
        chk("p1 latency done/len", {15'd0, str_done_a, str_len_a}, {15'd0, 1'b1, 16'd2});
        chk("p1 in_ready in TERM", 32'(in_ready_a), 32'd0);
        idle(0);
        repeat (3) @(negedge clk);
        check_phase(1);

        // Phases 2-3: table-driven string streams from a fresh reset
        for (int p = 2; p <= 3; p++) begin
            do_reset();
            evq.delete();
            for (int i = 0; i < n_stim; i++)
                if (stim_tab[i].phase == p) send_str(stim_tab[i].dut, stim_tab[i].s);
            repeat (4) @(negedge clk);
            check_phase(p);
            if (p == 2) begin
`ifdef STRBUF_READBACK_EN
                rd_en_a = 1'b1;
                rd_addr_a = 9'd0;
                @(negedge clk);
                chk("readback web", 32'(ram_web_a), 32'd0);
                rd_en_a = 1'b0;
                chk("readback data", rd_data_a, 32'h6463_6261);
`else
                chk("port B tied off", {ram_addrb_a, ram_enb_a, ram_web_a}, 11'd0);
`endif
            end
        end

        // Phase 4: 6-byte string into a 4-word RAM
        do_reset();
        evq.delete();
        for (int i = 0; i < 5; i++) begin
            push(2, 8'h11 + 8'(i), 1'b0, 20, acc);
            chk($sformatf("p4 accept byte%0d", i), 32'(acc), 32'd1);
        end
        push(2, 8'h16, 1'b1, 6, acc);
        chk("p4 byte5 refused", 32'(acc), 32'd0);
        drive(2, 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        chk("p4 full/in_ready/overflow", {29'd0, full_c, in_ready_c, overflow_c}, 32'd5);
        check_phase(4);

        // Phase 5: reset in the middle of a 32-bit string
        do_reset();
        evq.delete();
        push(0, 8'h61, 1'b0, 20, acc);
        push(0, 8'h62, 1'b0, 20, acc);
        push(0, 8'h63, 1'b0, 20, acc);
        chk("p5 accepted 3 bytes", 32'(acc), 32'd1);
        idle(0);
        do_reset();
        chk("p5 no write on reset", 32'(evq.size()), 32'd0);
        evq.delete();
        send_str(0, "q");
        repeat (4) @(negedge clk);
        check_phase(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
